// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions: default 1024x768 constants, the region
// code that describes where a counter sits on its axis, and small helpers.
package video_timing_pkg;

    localparam int DEF_CW       = 11;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    // Region order along an axis: active, front porch, sync, back porch.
    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_t;

    // Drive level of a sync pin: the configured active level while inside
    // the sync region, its complement elsewhere.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        sync_level = in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus a decode of which region
// (active / front porch / sync / back porch) the current position lies in.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CW     = 11,
    parameter int ACTIVE = 1024,
    parameter int FP     = 24,
    parameter int SYNC   = 136,
    parameter int BP     = 160
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output region_t       region
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] FP_START   = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BP_START   = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_r;
    logic          wrap_s;
    region_t       region_s;

    assign wrap_s = (cnt_r == LAST);

    // Position counter: steps on advance, returns to 0 after the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (advance) begin
            if (wrap_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Region decode of the current position.
    always_comb begin
        region_s = REG_ACTIVE;
        if (cnt_r < FP_START) begin
            region_s = REG_ACTIVE;
        end else if (cnt_r < SYNC_START) begin
            region_s = REG_FP;
        end else if (cnt_r < BP_START) begin
            region_s = REG_SYNC;
        end else begin
            region_s = REG_BP;
        end
    end

    assign cnt    = cnt_r;
    assign wrap   = wrap_s;
    assign region = region_s;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Two axis counters (h, v) produce the
// scan position; every output is registered one clock after counter state so
// syncs, de, coordinates and start pulses stay mutually aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CW       = DEF_CW,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          en,
    output logic          hSync,
    output logic          vSync,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (2 ** CW)) begin : g_h_total_chk
        $error("video_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (2 ** CW)) begin : g_v_total_chk
        $error("video_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0] h_cnt_s;
    logic [CW-1:0] v_cnt_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          v_adv_s;
    region_t       h_region_s;
    region_t       v_region_s;

    logic          de_next_s;
    logic          hs_next_s;
    logic          vs_next_s;
    logic          ls_next_s;
    logic          fs_next_s;

    logic          hsync_r;
    logic          vsync_r;
    logic          de_r;
    logic [CW-1:0] pixel_x_r;
    logic [CW-1:0] pixel_y_r;
    logic          line_start_r;
    logic          frame_start_r;

    // The line counter steps once per completed line, and only while running,
    // so v_cnt (and therefore vSync) changes exactly at h_cnt==0.
    assign v_adv_s = h_wrap_s & en;

    video_axis_counter #(
        .CW     (CW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (c),
        .rst_n   (rst_n),
        .advance (en),
        .cnt     (h_cnt_s),
        .wrap    (h_wrap_s),
        .region  (h_region_s)
    );

    video_axis_counter #(
        .CW     (CW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (c),
        .rst_n   (rst_n),
        .advance (v_adv_s),
        .cnt     (v_cnt_s),
        .wrap    (v_wrap_s),
        .region  (v_region_s)
    );

    // Output values derived from the current counter position.
    always_comb begin
        de_next_s = 1'b0;
        hs_next_s = ~HS_POL;
        vs_next_s = ~VS_POL;
        ls_next_s = 1'b0;
        fs_next_s = 1'b0;
        if ((h_region_s == REG_ACTIVE) && (v_region_s == REG_ACTIVE)) begin
            de_next_s = 1'b1;
        end else begin
            de_next_s = 1'b0;
        end
        hs_next_s = sync_level(h_region_s == REG_SYNC, HS_POL);
        vs_next_s = sync_level(v_region_s == REG_SYNC, VS_POL);
        if (h_cnt_s == {CW{1'b0}}) begin
            ls_next_s = 1'b1;
            fs_next_s = (v_cnt_s == {CW{1'b0}});
        end else begin
            ls_next_s = 1'b0;
            fs_next_s = 1'b0;
        end
    end

    // Output register: loads while running; when paused, blanks de and the
    // start pulses but holds syncs and coordinates.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            de_r          <= 1'b0;
            pixel_x_r     <= {CW{1'b0}};
            pixel_y_r     <= {CW{1'b0}};
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (en) begin
            hsync_r       <= hs_next_s;
            vsync_r       <= vs_next_s;
            de_r          <= de_next_s;
            pixel_x_r     <= h_cnt_s;
            pixel_y_r     <= v_cnt_s;
            line_start_r  <= ls_next_s;
            frame_start_r <= fs_next_s;
        end else begin
            hsync_r       <= hsync_r;
            vsync_r       <= vsync_r;
            de_r          <= 1'b0;
            pixel_x_r     <= pixel_x_r;
            pixel_y_r     <= pixel_y_r;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign hSync       = hsync_r;
    assign vSync       = vsync_r;
    assign de          = de_r;
    assign pixel_x     = pixel_x_r;
    assign pixel_y     = pixel_y_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster (16x8 total, 8x4 visible).
// Two instances share stimulus: one with active-low syncs, one active-high.
// A position-based reference model predicts every output each clock.
module tb_video_timing_gen;

    localparam int CW = 5;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic c = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b1;

    logic          hs0, vs0, de0, ls0, fs0;
    logic [CW-1:0] x0, y0;
    logic          hs1, vs1, de1, ls1, fs1;
    logic [CW-1:0] x1, y1;

    always #5 c = ~c;

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut0 (
        .c(c), .rst_n(rst_n), .en(en),
        .hSync(hs0), .vSync(vs0), .de(de0), .pixel_x(x0), .pixel_y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut1 (
        .c(c), .rst_n(rst_n), .en(en),
        .hSync(hs1), .vSync(vs1), .de(de1), .pixel_x(x1), .pixel_y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scan position plus expected outputs ("in sync" flags
    // are polarity-free; each instance maps them to its own level).
    int mh = 0, mv = 0;
    int e_x = 0, e_y = 0;
    bit e_de = 1'b0, e_hsa = 1'b0, e_vsa = 1'b0, e_ls = 1'b0, e_fs = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; e_x = 0; e_y = 0;
        e_de = 1'b0; e_hsa = 1'b0; e_vsa = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (en) begin
            e_x   = mh;
            e_y   = mv;
            e_de  = (mh < HA) && (mv < VA);
            e_hsa = (mh >= HA + HF) && (mh < HA + HF + HS);
            e_vsa = (mv >= VA + VF) && (mv < VA + VF + VS);
            e_ls  = (mh == 0);
            e_fs  = (mh == 0) && (mv == 0);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end else begin
            e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("de0", int'(de0), int'(e_de));
        check("x0",  int'(x0),  e_x);
        check("y0",  int'(y0),  e_y);
        check("hs0", int'(hs0), int'(!e_hsa));
        check("vs0", int'(vs0), int'(!e_vsa));
        check("ls0", int'(ls0), int'(e_ls));
        check("fs0", int'(fs0), int'(e_fs));
        check("de1", int'(de1), int'(e_de));
        check("x1",  int'(x1),  e_x);
        check("y1",  int'(y1),  e_y);
        check("hs1", int'(hs1), int'(e_hsa));
        check("vs1", int'(vs1), int'(e_vsa));
        check("ls1", int'(ls1), int'(e_ls));
        check("fs1", int'(fs1), int'(e_fs));
    endtask

    // One clock: model follows the edge, DUTs are sampled on the falling edge.
    task automatic step();
        @(posedge c);
        model_edge();
        @(negedge c);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_de"}, int'(de0), 0);
        check({tag, "_x"},  int'(x0), 0);
        check({tag, "_y"},  int'(y0), 0);
        check({tag, "_hs0"}, int'(hs0), 1);
        check({tag, "_vs0"}, int'(vs0), 1);
        check({tag, "_hs1"}, int'(hs1), 0);
        check({tag, "_vs1"}, int'(vs1), 0);
        check({tag, "_ls"}, int'(ls0), 0);
        check({tag, "_fs"}, int'(fs0), 0);
    endtask

    initial begin : main
        int de_cnt, hs_lo, vs_lo, fs_cnt, last_fs, prev_vs;
        bit found;

        // Asynchronous reset assertion with no clock edge in between.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        model_reset();
        step();
        step();

        // Release: first clock presents (0,0) with both start pulses.
        rst_n = 1'b1;
        en = 1'b1;
        step();
        check("first_de", int'(de0), 1);
        check("first_fs", int'(fs0), 1);
        check("first_ls", int'(ls0), 1);
        check("first_hs", int'(hs0), 1);
        check("first_vs", int'(vs0), 1);

        // Free run of two whole frames with aggregate timing checks.
        de_cnt = int'(de0); hs_lo = int'(!hs0); vs_lo = int'(!vs0);
        fs_cnt = 1; last_fs = 0; prev_vs = int'(vs0);
        for (int i = 1; i < 2 * HT * VT; i++) begin
            step();
            de_cnt += int'(de0);
            hs_lo  += int'(!hs0);
            vs_lo  += int'(!vs0);
            if (fs0) begin
                fs_cnt++;
                check("fs_period", i - last_fs, HT * VT);
                last_fs = i;
            end
            if (int'(vs0) != prev_vs) check("vs_edge_ls", int'(ls0), 1);
            prev_vs = int'(vs0);
        end
        check("de_total", de_cnt, 2 * HA * VA);
        check("hs_low_total", hs_lo, 2 * HS * VT);
        check("vs_low_total", vs_lo, 2 * VS * HT);
        check("fs_count", fs_cnt, 2);

        // Pause after pixel x=5 of a visible line for 4 clocks.
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !found; i++) begin
            step();
            if (e_de && e_x == 5) found = 1'b1;
        end
        check("gap_found", int'(found), 1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("gap_de", int'(de0), 0);
            check("gap_x", int'(x0), 5);
        end
        en = 1'b1;
        step();
        check("resume_x", int'(x0), 6);
        check("resume_de", int'(de0), 1);

        // Randomized run enable.
        for (int i = 0; i < 2000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset mid-frame at line 3.
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !found; i++) begin
            step();
            if (e_y == 3 && e_x == 4) found = 1'b1;
        end
        check("midrst_found", int'(found), 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_fs", int'(fs0), 1);
        check("post_rst_x", int'(x0), 0);
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
